// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants for the DES key-schedule slice: fixed widths, the PC-1
// selection table, the per-round left-shift schedule and the FSM encoding.
// Table entries use the DES convention of bit 1 = MSB.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int KEY_W = 64;
    localparam int CD_W  = 56;
    localparam int SK_W  = 48;

    // FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // PC-1: output bit i takes key bit PC1_TAB[i]; parity bits never appear.
    localparam int PC1_TAB [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Left-shift amount applied to produce CD[i] from CD[i-1].
    localparam int SHIFTS [1:16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

endpackage

// File: rtl/PC2.sv
// -----------------------------------------------------------------------------
// PC2
// Combinational DES Permuted Choice 2 (selects the 48-bit round subkey).
//   in  [1:56] : C||D register, bit 1 = MSB
//   out [1:48] : round subkey
// -----------------------------------------------------------------------------
module PC2 (
    input  logic [1:56] in,
    output logic [1:48] out
);

    localparam int PC2_TAB [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    for (genvar i = 1; i <= 48; i++) begin : g_sel
        assign out[i] = in[PC2_TAB[i]];
    end

endmodule

// File: rtl/des_pc1.sv
// -----------------------------------------------------------------------------
// des_pc1
// Combinational DES Permuted Choice 1.
//   in  [1:64] : 64-bit key, bit 1 = MSB (parity bits 8,16,..,64 dropped)
//   out [1:56] : C0 (bits 1..28) concatenated with D0 (bits 29..56)
// -----------------------------------------------------------------------------
module des_pc1
    import des_pkg::*;
(
    input  logic [1:64] in,
    output logic [1:56] out
);

    for (genvar i = 1; i <= 56; i++) begin : g_sel
        assign out[i] = in[PC1_TAB[i]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Sequential DES key schedule. A start captures the key through PC-1 and the
// C/D halves are then rotated one round per consumer 'next'. Encrypt order
// presents K1..K16; decrypt order presents K16..K1 by rotating right from
// C0D0 (which equals CD16, since the total shift is 28).
//
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   key      : [1:64] DES key, bit 1 = MSB
//   start    : begin a schedule (ignored while busy)
//   decrypt  : direction, sampled with start
//   next     : consumer took the current subkey; advance one round
//   cd       : [1:56] current C||D register
//   subkey   : [1:48] PC2(cd), combinational
//   round    : index of the presented subkey step, 0..15
//   valid    : cd/subkey/round are live
//   busy     : schedule in progress (same as valid)
//   done     : one-cycle pulse after the 16th subkey is consumed
// -----------------------------------------------------------------------------
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:64] key,
    input  logic        start,
    input  logic        decrypt,
    input  logic        next,
    output logic [1:56] cd,
    output logic [1:48] subkey,
    output logic [3:0]  round,
    output logic        valid,
    output logic        busy,
    output logic        done
);

    logic [0:0]  state;
    logic        dir_q;
    logic [1:56] cd_q;
    logic [3:0]  round_q;
    logic        done_q;

    logic [1:56] pc1_cd;
    logic [1:56] load_cd;
    logic [1:56] step_cd;
    logic        load_two;
    logic        enc_two;
    logic        dec_two;
    int          enc_idx;
    int          dec_idx;

    function automatic logic [1:28] rotl28(input logic [1:28] x, input logic two);
        rotl28 = two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr28(input logic [1:28] x, input logic two);
        rotr28 = two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    des_pc1 u_pc1 (
        .in  (key),
        .out (pc1_cd)
    );

    PC2 u_pc2 (
        .in  (cd_q),
        .out (subkey)
    );

    // Presenting round r in encrypt order means CD(r+1) is loaded, so the
    // step to round r+1 applies S[r+2]. In decrypt order round r shows
    // CD(16-r) and the step back to CD(15-r) undoes S[16-r]. enc_idx is
    // clamped because round 15 never steps.
    always_comb begin
        enc_idx  = (round_q == 4'd15) ? 16 : int'(round_q) + 2;
        dec_idx  = 16 - int'(round_q);
        enc_two  = (SHIFTS[enc_idx] == 2);
        dec_two  = (SHIFTS[dec_idx] == 2);
        load_two = (SHIFTS[1] == 2);

        if (decrypt) begin
            load_cd = pc1_cd;
        end else begin
            load_cd = {rotl28(pc1_cd[1:28], load_two), rotl28(pc1_cd[29:56], load_two)};
        end

        if (dir_q) begin
            step_cd = {rotr28(cd_q[1:28], dec_two), rotr28(cd_q[29:56], dec_two)};
        end else begin
            step_cd = {rotl28(cd_q[1:28], enc_two), rotl28(cd_q[29:56], enc_two)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            dir_q   <= 1'b0;
            cd_q    <= '0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cd_q    <= load_cd;
                        dir_q   <= decrypt;
                        round_q <= 4'd0;
                        state   <= ST_RUN;
                    end
                end
                default: begin
                    if (next) begin
                        if (round_q == 4'd15) begin
                            // cd and round keep their final values
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            cd_q    <= step_cd;
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign cd    = cd_q;
    assign round = round_q;
    assign valid = (state == ST_RUN);
    assign busy  = (state == ST_RUN);
    assign done  = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench: stimulus pushes the expected 16 presentations of every
// schedule; a negedge monitor pops one per presentation and checks holds.
module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic [1:64] key;
    logic        start;
    logic        decrypt;
    logic        next;
    logic [1:56] cd;
    logic [1:48] subkey;
    logic [3:0]  round;
    logic        valid;
    logic        busy;
    logic        done;

    des_key_schedule dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .start   (start),
        .decrypt (decrypt),
        .next    (next),
        .cd      (cd),
        .subkey  (subkey),
        .round   (round),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:56] cd;
        logic [1:48] sk;
        logic [3:0]  rnd;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [1:56] first_cd;
    logic [1:48] first_sk;
    logic [1:48] last_sk;

    localparam int M_PC1 [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    // cumulative left shift from C0D0 to CDi
    localparam int M_CUM [1:16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [1:28] mrot(input logic [1:28] x, input int n);
        logic [1:28] r;
        for (int i = 1; i <= 28; i++) r[i] = x[((i - 1 + n) % 28) + 1];
        return r;
    endfunction

    task automatic push_sched(input logic [1:64] k, input logic dec);
        logic [1:56] c0d0;
        logic [1:56] cdx;
        logic [1:48] skx;
        exp_t        e;
        int          idx;
        for (int i = 1; i <= 56; i++) c0d0[i] = k[M_PC1[i]];
        for (int r = 0; r < 16; r++) begin
            idx = dec ? (16 - r) : (r + 1);
            cdx = {mrot(c0d0[1:28], M_CUM[idx]), mrot(c0d0[29:56], M_CUM[idx])};
            for (int i = 1; i <= 48; i++) skx[i] = cdx[M_PC2[i]];
            e.cd  = cdx;
            e.sk  = skx;
            e.rnd = 4'(r);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: a presentation happens at an edge where start is accepted in
    // idle or next advances a non-final round; done follows a final next.
    logic pres_pend = 1'b0;
    logic done_pend = 1'b0;
    logic have_last = 1'b0;
    exp_t last_e;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pres_pend <= 1'b0;
            done_pend <= 1'b0;
            have_last <= 1'b0;
        end else begin
            if (pres_pend) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_cd", 64'(cd), 64'(e.cd));
                    chk("sb_subkey", 64'(subkey), 64'(e.sk));
                    chk("sb_round", 64'(round), 64'(e.rnd));
                    chk("sb_valid", 64'(valid), 64'd1);
                    last_e    <= e;
                    have_last <= 1'b1;
                end
            end else if (valid && have_last) begin
                chk("hold_cd", 64'(cd), 64'(last_e.cd));
                chk("hold_subkey", 64'(subkey), 64'(last_e.sk));
                chk("hold_round", 64'(round), 64'(last_e.rnd));
            end
            chk("done_timing", 64'(done), 64'(done_pend));
            chk("busy_eq_valid", 64'(busy), 64'(valid));
            pres_pend <= (!valid && start) || (valid && next && round != 4'd15);
            done_pend <= valid && next && round == 4'd15;
        end
    end

    // Called at posedge+2; returns at posedge+2 of the done cycle (or after
    // a reset abort), so a following call starts back-to-back.
    task automatic run(input logic [1:64] k, input logic dec, input bit rnd,
                       input bit snext, input int ign_at, input int rst_at);
        int acc;
        int cyc;
        bit ign_done;
        key     = k;
        decrypt = dec;
        start   = 1'b1;
        next    = snext;
        push_sched(k, dec);
        @(posedge clk); #2;
        first_cd = cd;
        first_sk = subkey;
        start    = 1'b0;
        key      = {$urandom, $urandom};
        decrypt  = ~dec;
        acc      = 0;
        cyc      = 0;
        ign_done = 1'b0;
        while (acc < 16 && cyc < 200) begin
            if (acc == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_cd", 64'(cd), 64'd0);
                chk("rst_subkey", 64'(subkey), 64'd0);
                chk("rst_round", 64'(round), 64'd0);
                chk("rst_valid", 64'(valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                @(posedge clk); #2;
                rst   = 1'b0;
                next  = 1'b0;
                start = 1'b0;
                sb_q.delete();
                return;
            end
            if (acc == ign_at && !ign_done) begin
                start    = 1'b1;
                key      = ~k;
                decrypt  = ~dec;
                next     = 1'b0;
                ign_done = 1'b1;
            end else begin
                start = 1'b0;
                next  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clk); #2;
            if (next) acc++;
            if (acc == 15) last_sk = subkey;
            cyc++;
        end
        start = 1'b0;
        next  = 1'b0;
        if (cyc >= 200) chk("run_timeout", 64'(cyc), 64'd0);
        chk("done_pulse", 64'(done), 64'd1);
    endtask

    localparam logic [1:64] KA = 64'h133457799BBCDFF1;
    localparam logic [1:64] KB = 64'h0E329232EA6D0D73;
    localparam logic [1:64] KC = 64'hA5F0_3C96_1234_FEDC;

    initial begin
        logic [1:64] wk;
        rst     = 1'b1;
        key     = '0;
        start   = 1'b0;
        decrypt = 1'b0;
        next    = 1'b0;
        #1;
        chk("init_cd", 64'(cd), 64'd0);
        chk("init_subkey", 64'(subkey), 64'd0);
        chk("init_round", 64'(round), 64'd0);
        chk("init_valid", 64'(valid), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_done", 64'(done), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        // encrypt, free-running next
        run(KA, 1'b0, 1'b0, 1'b0, -1, -1);
        chk("enc_cd1", 64'(first_cd), 64'({28'hE19955F, 28'hAACCF1E}));
        chk("enc_k1", 64'(first_sk), 64'h1B02EFFC7072);
        chk("enc_k16", 64'(last_sk), 64'hCB3D8B0E17F5);
        @(posedge clk); #2;

        // decrypt order
        run(KA, 1'b1, 1'b0, 1'b0, -1, -1);
        chk("dec_cd16", 64'(first_cd), 64'({28'hF0CCAAF, 28'h556678F}));
        chk("dec_first", 64'(first_sk), 64'hCB3D8B0E17F5);
        chk("dec_last", 64'(last_sk), 64'h1B02EFFC7072);
        @(posedge clk); #2;

        // back-pressure
        run(KA, 1'b0, 1'b1, 1'b0, -1, -1);
        run(KB, 1'b1, 1'b1, 1'b0, -1, -1);
        @(posedge clk); #2;

        // start ignored mid-run at round 5
        run(KB, 1'b0, 1'b1, 1'b0, 5, -1);
        @(posedge clk); #2;

        // next in idle leaves round alone
        next = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        next = 1'b0;
        chk("idle_next_round", 64'(round), 64'd15);
        chk("idle_next_valid", 64'(valid), 64'd0);

        // start and next together in idle
        run(KC, 1'b1, 1'b0, 1'b1, -1, -1);
        @(posedge clk); #2;

        // reset mid-schedule at round 7, then a clean restart
        run(KA, 1'b0, 1'b0, 1'b0, -1, 7);
        chk("post_rst_done", 64'(done), 64'd0);
        run(KB, 1'b0, 1'b0, 1'b0, -1, -1);

        // walking-1 keys, back-to-back
        for (int p = 1; p <= 64; p++) begin
            if (p % 8 != 0) begin
                wk = '0;
                wk[p] = 1'b1;
                run(wk, 1'b0, 1'b0, 1'b0, -1, -1);
                run(wk, 1'b1, 1'b0, 1'b0, -1, -1);
            end
        end

        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule engine that sits directly upstream of the PC2 stage. It captures a 64-bit key, applies PC-1, and steps the 28-bit C/D halves through the 16 rotation rounds, one round per consumer request. Each round's 56-bit C‖D goes to an internal PC2 instance, and both C‖D and the 48-bit subkey are presented to the round engine. Encrypt order yields K1..K16; decrypt order yields K16..K1 with no precompute pass.

## Interface
Parameters: none. All widths are fixed by DES.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; asynchronous, active-high
- `key`  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,…,64 ignored
- `start`  in  1  accept `key`/`decrypt` and begin a schedule; honoured only when `busy`=0
- `decrypt`  in  1  sampled with `start`; 0 = encrypt order, 1 = decrypt order
- `next`  in  1  consumer has taken the current subkey; advance one round
- `cd`  out  [1:56]  current C‖D register (C = 1..28, D = 29..56)
- `subkey`  out  [1:48]  PC2(`cd`), combinational from the register
- `round`  out  4  index of the presented subkey step, 0..15
- `valid`  out  1  `cd`/`subkey`/`round` hold a live round
- `busy`  out  1  schedule in progress (equals `valid`)
- `done`  out  1  one-cycle pulse after the 16th subkey is consumed

## Operation
- **States:** IDLE and RUN.
- **IDLE + `start`:**
  - Load `cd` with PC1(`key`).
  - Encrypt: also rotate left by 1 in the same edge, so `cd` = CD1.
  - Decrypt: no rotation, so `cd` = C0D0 = CD16.
  - Latch the direction, set `round`=0 and `valid`=1, go to RUN.
- **Shift schedule** S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Cumulative shift = 28.
- **RUN + `next`, `round`=r<15:**
  - Encrypt: rotate C and D left independently by S[r+2].
  - Decrypt: rotate C and D right independently by S[16−r].
  - Then `round`←r+1.
- **RUN + `next`, `round`=15:**
  - `valid`←0, `done`←1 for one cycle, go to IDLE.
  - `cd` and `round` hold their last values.
- **RUN without `next`:** hold all outputs. No timeout.
- **Ignored inputs:**
  - `start` while in RUN.
  - `next` while in IDLE.
  - `key`/`decrypt` changes after the `start` edge.
- **Simultaneous `start` and `next` in IDLE:** `start` wins; `next` ignored.
- **`start` in the `done` cycle:** the state is IDLE, so it is accepted.
- **Rotations:** confined to each 28-bit half; no carry between C and D.

## Timing
- **Reset** (async assert, takes effect immediately):
  - `cd`=0, `round`=0, `valid`=0, `busy`=0, `done`=0.
  - `subkey`=PC2(0)=0.
  - State = IDLE, latched direction = encrypt.
- **Reset mid-schedule:** aborts with no `done` pulse; the next `start` restarts cleanly.
- **Latency:**
  - `start` at edge t → first subkey valid after t.
  - Each `next` at edge t → next subkey valid after t.
  - Sustained `next`=1 gives 16 subkeys in 16 cycles.
- **`subkey` path:** purely combinational from the `cd` register; no pipeline stage.

## Structure
- **Shared package `des_pkg`:**
  - PC1 index constant (56 entries).
  - Shift schedule S[1..16].
  - State encoding.
  - Width localparams (KEY_W=64, CD_W=56, SK_W=48).
- **Sub-module `des_pc1`:** combinational PC-1 permutation, ports `in[1:64]`, `out[1:56]`, mirroring the existing PC2 module.
- **PC2:** the existing `PC2` module is instantiated unchanged on `cd`.

## Test plan
1. **Reset:** assert `rst` mid-RUN at `round`=7 → all outputs 0 immediately, no `done`. Next `start` yields `round`=0.
2. **Encrypt, free-run `next`:** `key`=133457799BBCDFF1, `decrypt`=0, `start` → after one edge:
   - `cd` = C1 E19955F, D1 AACCF1E.
   - `subkey`=1B02EFFC7072.
   - Holding `next`=1: `round` 15 shows `subkey`=CB3D8B0E17F5, then `done` pulses once.
3. **Decrypt order:** same key, `decrypt`=1 → first `subkey`=CB3D8B0E17F5 (`cd`=C0 F0CCAAF, D0 556678F). Sixteenth `subkey`=1B02EFFC7072; all 16 subkeys equal the encrypt run reversed.
4. **Back-pressure:** `next` toggled randomly → `subkey` stable while `next`=0; no round skipped or repeated. Compare against a reference model of rotations plus PC2.
5. **Ignored inputs:**
   - `start` with a different key at `round`=5 → no effect.
   - `next` in IDLE → `round` unchanged.
   - `start`+`next` together in IDLE → `round`=0.
6. **Back-to-back:** `start` in the `done` cycle → new schedule begins the next cycle. Walking-1 keys over all 56 non-parity bits (encrypt and decrypt) → 16 subkeys match the model each time.
